// File: rtl/ski_ram_arbiter_pkg.sv
// Shared encodings, FSM state and width helpers for the SKI RAM arbiter.
package ski_ram_arbiter_pkg;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 63;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [1:0] TAG_IDLE    = 2'b00;
  localparam logic [1:0] TAG_RD_DONE = 2'b01;
  localparam logic [1:0] TAG_WR_DONE = 2'b10;
  localparam logic [1:0] TAG_ERR     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // {op, addr, data}
  function automatic int req_w(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

  // {tag, data}
  function automatic int sts_w(input int dw);
    return 2 + dw;
  endfunction

  // Only read and write are real work; none and reserved are ignored.
  function automatic logic op_pending(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/ski_rr_pick2.sv
// Two-way round-robin picker: on a tie the side that did not win last time wins.
module ski_rr_pick2 (
  input  logic i_pend0,
  input  logic i_pend1,
  input  logic i_last,
  output logic o_gnt_vld,
  output logic o_gnt_idx
);

  // Grant decode
  always_comb begin
    o_gnt_vld = i_pend0 | i_pend1;
    o_gnt_idx = 1'b0;
    if (i_pend0 && i_pend1) o_gnt_idx = ~i_last;
    else if (i_pend1)       o_gnt_idx = 1'b1;
  end

endmodule

// File: rtl/ski_ram_arbiter.sv
// Shares the SKI machine RAM port between the reduction CPU (index 0) and the
// host loader (index 1). One transaction in flight; a stalled RAM becomes an
// error completion after TIMEOUT busy cycles.
module ski_ram_arbiter
  import ski_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic [2+ADDR_W+DATA_W-1:0] cpu_req_i,
  output logic [2+DATA_W-1:0]        cpu_status_o,
  input  logic [2+ADDR_W+DATA_W-1:0] host_req_i,
  output logic [2+DATA_W-1:0]        host_status_o,
  output logic [2+ADDR_W+DATA_W-1:0] ram_req_o,
  input  logic [2+DATA_W-1:0]        ram_status_i,
  output logic                       err_o
);

  localparam int REQ_W = req_w(ADDR_W, DATA_W);
  localparam int STS_W = sts_w(DATA_W);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t           r_state, w_nxt;
  logic             r_owner, r_last, r_err;
  logic [REQ_W-1:0] r_req;
  logic [STS_W-1:0] r_sts;
  logic [15:0]      r_cnt;

  logic        w_cpu_pend, w_host_pend, w_gnt_vld, w_gnt_idx;
  logic [1:0]  w_ram_tag;
  logic        w_ram_done, w_timeout;
  logic [15:0] w_cnt_nxt;

  assign w_cpu_pend  = op_pending(cpu_req_i[REQ_W-1 -: 2]);
  assign w_host_pend = op_pending(host_req_i[REQ_W-1 -: 2]);
  assign w_ram_tag   = ram_status_i[STS_W-1 -: 2];
  // Error tag from RAM completes the transaction just like a done tag.
  assign w_ram_done  = (w_ram_tag != TAG_IDLE);
  assign w_cnt_nxt   = r_cnt + 16'd1;
  // A done tag in the same cycle beats the timeout.
  assign w_timeout   = !w_ram_done && (w_cnt_nxt == TMO);

  ski_rr_pick2 u_pick (
    .i_pend0  (w_cpu_pend),
    .i_pend1  (w_host_pend),
    .i_last   (r_last),
    .o_gnt_vld(w_gnt_vld),
    .o_gnt_idx(w_gnt_idx)
  );

  // State register
  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) r_state <= ST_IDLE;
    else                  r_state <= w_nxt;

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_vld)               w_nxt = ST_BUSY;
      ST_BUSY: if (w_ram_done || w_timeout) w_nxt = ST_RESP;
      ST_RESP:                              w_nxt = ST_IDLE;
      default:                              w_nxt = ST_IDLE;
    endcase
  end

  // Grant latch, completion latch, timeout counter and sticky error.
  // last_grant resets to host so the CPU wins the first tie.
  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_req   <= '0;
      r_sts   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_gnt_vld) begin
          r_owner <= w_gnt_idx;
          r_last  <= w_gnt_idx;
          r_req   <= w_gnt_idx ? host_req_i : cpu_req_i;
          r_cnt   <= '0;
        end
        ST_BUSY: if (w_ram_done) begin
          r_sts <= ram_status_i;
        end else begin
          r_cnt <= w_cnt_nxt;
          if (w_timeout) begin
            r_sts <= {TAG_ERR, {DATA_W{1'b0}}};
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end

  // Outputs decoded from registered state only
  always_comb begin
    ram_req_o     = '0;
    cpu_status_o  = '0;
    host_status_o = '0;
    if (r_state == ST_BUSY) ram_req_o = r_req;
    if (r_state == ST_RESP) begin
      if (r_owner) host_status_o = r_sts;
      else         cpu_status_o  = r_sts;
    end
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_ski_ram_arbiter.sv
// Directed bench for ski_ram_arbiter: main instance with default TIMEOUT plus a
// second instance with TIMEOUT = 8 for timeout behaviour.
module tb_ski_ram_arbiter;
  import ski_ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [94:0] cpu_req = '0, host_req = '0, ram_req;
  logic [64:0] ram_sts = '0, cpu_sts, host_sts;
  logic        err;
  logic [94:0] t_cpu = '0, t_host = '0, t_ram;
  logic [64:0] t_rsts = '0, t_csts, t_hsts;
  logic        t_err;

  int n_chk = 0;
  int n_fail = 0;

  ski_ram_arbiter u_dut (
    .system1000(clk), .system1000_rstn(rstn),
    .cpu_req_i(cpu_req), .cpu_status_o(cpu_sts),
    .host_req_i(host_req), .host_status_o(host_sts),
    .ram_req_o(ram_req), .ram_status_i(ram_sts), .err_o(err)
  );

  ski_ram_arbiter #(.TIMEOUT(8)) u_to (
    .system1000(clk), .system1000_rstn(rstn),
    .cpu_req_i(t_cpu), .cpu_status_o(t_csts),
    .host_req_i(t_host), .host_status_o(t_hsts),
    .ram_req_o(t_ram), .ram_status_i(t_rsts), .err_o(t_err)
  );

  function automatic logic [94:0] mkreq(input logic [1:0] op, input logic [29:0] a, input logic [62:0] d);
    return {op, a, d};
  endfunction

  function automatic logic [64:0] mksts(input logic [1:0] tg, input logic [62:0] d);
    return {tg, d};
  endfunction

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; tick(); tick(); rstn = 1'b1;
  endtask

  // From IDLE with request presented: BUSY for stall+1 cycles, then RESP.
  task automatic serve(input string nm, input bit own, input logic [94:0] rq,
                       input int stall, input logic [64:0] st);
    tick(); chk({nm, "_req"}, ram_req, rq);
    for (int i = 0; i < stall; i++) begin
      ram_sts = '0; tick(); chk({nm, "_hold"}, ram_req, rq);
    end
    ram_sts = st; tick();
    chk({nm, "_own"}, own ? host_sts : cpu_sts, st);
    chk({nm, "_oth"}, own ? cpu_sts : host_sts, '0);
    chk({nm, "_ramz"}, ram_req, '0);
    ram_sts = '0;
  endtask

  task automatic idle_chk(input string nm);
    tick();
    chk({nm, "_ram"}, ram_req, '0);
    chk({nm, "_cpu"}, cpu_sts, '0);
    chk({nm, "_host"}, host_sts, '0);
  endtask

  initial begin
    // Reset state
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle_chk("rst");
      chk("rst_err", err, 1'b0);
    end

    // CPU read, RAM done on first BUSY cycle
    cpu_req = mkreq(OP_READ, 30'h5, 63'h0);
    serve("rd", 1'b0, mkreq(OP_READ, 30'h5, 63'h0), 0, mksts(TAG_RD_DONE, 63'h1234));
    cpu_req = '0;
    idle_chk("rd_after");

    // Tie-break from reset: CPU first, then alternation
    do_reset();
    cpu_req  = mkreq(OP_WRITE, 30'h10, 63'hAA);
    host_req = mkreq(OP_READ, 30'h20, 63'h0);
    serve("t0c", 1'b0, mkreq(OP_WRITE, 30'h10, 63'hAA), 1, mksts(TAG_WR_DONE, 63'h0));
    cpu_req = mkreq(OP_WRITE, 30'h11, 63'hBB);
    idle_chk("t0i");
    serve("t1h", 1'b1, mkreq(OP_READ, 30'h20, 63'h0), 1, mksts(TAG_RD_DONE, 63'h55));
    host_req = mkreq(OP_READ, 30'h21, 63'h0);
    idle_chk("t1i");
    serve("t2c", 1'b0, mkreq(OP_WRITE, 30'h11, 63'hBB), 1, mksts(TAG_WR_DONE, 63'h0));
    cpu_req = '0;
    idle_chk("t2i");
    serve("t3h", 1'b1, mkreq(OP_READ, 30'h21, 63'h0), 1, mksts(TAG_RD_DONE, 63'h66));
    host_req = '0;
    idle_chk("t3i");

    // Host write under a 50-cycle RAM stall
    host_req = mkreq(OP_WRITE, 30'h30, 63'h77);
    serve("stall", 1'b1, mkreq(OP_WRITE, 30'h30, 63'h77), 50, mksts(TAG_WR_DONE, 63'h0));
    host_req = '0;
    chk("stall_err", err, 1'b0);
    idle_chk("stall_i");

    // TIMEOUT=8: done on the 8th BUSY cycle wins over the timeout
    t_cpu = mkreq(OP_READ, 30'h1, 63'h0);
    tick(); chk("tb_busy", t_ram, mkreq(OP_READ, 30'h1, 63'h0));
    repeat (7) tick();
    chk("tb_busy8", t_ram, mkreq(OP_READ, 30'h1, 63'h0));
    t_rsts = mksts(TAG_RD_DONE, 63'h99);
    tick();
    chk("tb_sts", t_csts, mksts(TAG_RD_DONE, 63'h99));
    chk("tb_err", t_err, 1'b0);
    t_rsts = '0; t_cpu = '0;
    tick(); chk("tb_idle", t_csts, '0);

    // TIMEOUT=8: RAM never completes
    t_host = mkreq(OP_WRITE, 30'h2, 63'h3);
    tick(); chk("to_busy", t_ram, mkreq(OP_WRITE, 30'h2, 63'h3));
    repeat (7) tick();
    chk("to_busy8", t_ram, mkreq(OP_WRITE, 30'h2, 63'h3));
    chk("to_pre", t_hsts, '0);
    tick();
    chk("to_sts", t_hsts, mksts(TAG_ERR, 63'h0));
    chk("to_cpu", t_csts, '0);
    chk("to_err", t_err, 1'b1);
    t_host = '0;
    tick();
    chk("to_once", t_hsts, '0);
    chk("to_sticky", t_err, 1'b1);
    t_cpu = mkreq(OP_READ, 30'h4, 63'h0);
    tick(); chk("to_next_req", t_ram, mkreq(OP_READ, 30'h4, 63'h0));
    t_rsts = mksts(TAG_RD_DONE, 63'h42);
    tick();
    chk("to_next_sts", t_csts, mksts(TAG_RD_DONE, 63'h42));
    chk("to_next_err", t_err, 1'b1);
    t_rsts = '0; t_cpu = '0;
    tick();

    // Reset during BUSY: request drops asynchronously, no status afterwards
    cpu_req = mkreq(OP_READ, 30'h7, 63'h0);
    tick(); chk("mid_busy", ram_req, mkreq(OP_READ, 30'h7, 63'h0));
    #2 rstn = 1'b0;
    #1 chk("mid_async", ram_req, '0);
    chk("mid_err_clr", t_err, 1'b0);
    cpu_req = '0;
    tick(); rstn = 1'b1;
    ram_sts = mksts(TAG_RD_DONE, 63'hDEAD);
    for (int i = 0; i < 4; i++) idle_chk("mid_post");

    // Reserved op on both sides is never granted
    cpu_req  = mkreq(2'b11, 30'h8, 63'h1);
    host_req = mkreq(2'b11, 30'h9, 63'h2);
    for (int i = 0; i < 5; i++) idle_chk("rsvd");
    cpu_req = '0; host_req = '0; ram_sts = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
